npuarc_alb_dmp_ibp_fifo: RTL and testbench

//  Parametrised multi-entry valid/ready FIFO for DMP IBP channels (cmd, wdata, rdata, wresp).

---
 rtl/npuarc_alb_dmp_ibp_fifo_pkg.sv | 25 ++
 rtl/npuarc_alb_dmp_ibp_fifo_mem.sv | 43 ++++
 rtl/npuarc_alb_dmp_ibp_fifo.sv | 126 ++++++++++++
 tb/tb_npuarc_alb_dmp_ibp_fifo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/npuarc_alb_dmp_ibp_fifo_pkg.sv
// Shared sizing helpers and handshake encoding for the DMP IBP FIFO.
// Used by npuarc_alb_dmp_ibp_fifo and npuarc_alb_dmp_ibp_fifo_mem.
package npuarc_alb_dmp_ibp_fifo_pkg;

  // Per-cycle pointer activity, packed as {push, pop}
  typedef enum logic [1:0] {
    IFOP_IDLE = 2'b00,
    IFOP_POP  = 2'b01,
    IFOP_PUSH = 2'b10,
    IFOP_BOTH = 2'b11
  } ifop_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/npuarc_alb_dmp_ibp_fifo_mem.sv
// DEPTH x WIDTH flop storage: one-hot per-entry write enable, async read mux.
// Holds no reset; contents are only meaningful behind the top-level pointers.
module npuarc_alb_dmp_ibp_fifo_mem
  import npuarc_alb_dmp_ibp_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] we_s;

  // One-hot decode so each entry sees its own clock-gate enable
  always_comb begin
    we_s = {DEPTH{1'b0}};
    for (int e = 0; e < DEPTH; e++) begin
      we_s[e] = wr_en & (wr_idx == PTR_W'(e));
    end
  end

  // Entry flops, written only when selected
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (we_s[e]) begin
        mem_r[e] <= wr_data;
      end
    end
  end

  // Async read of the head entry
  always_comb begin
    rd_data = mem_r[rd_idx];
  end

endmodule

// File: rtl/npuarc_alb_dmp_ibp_fifo.sv
// Multi-entry valid/ready FIFO for DMP IBP channels with count, almost-full and flush.
// Define NPUARC_IBP_FIFO_BYPASS_EN for the zero-latency empty bypass.
module npuarc_alb_dmp_ibp_fifo
  import npuarc_alb_dmp_ibp_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_afull
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("npuarc_alb_dmp_ibp_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [PTR_W:0]   wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic             empty_s, full_s;
  logic             rd_en_s, wr_en_s, push_s, pop_s, byp_s;
  logic [WIDTH-1:0] mem_rd_s;
  ifop_e            op_s;

  // Handshake: flush masks both sides so nothing moves in that cycle
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]) &&
              (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]);
`ifdef NPUARC_IBP_FIFO_BYPASS_EN
    byp_s   = empty_s & i_valid & ~flush;
    o_valid = (~empty_s | i_valid) & ~flush;
    if (empty_s) begin
      o_data = i_data;
    end else begin
      o_data = mem_rd_s;
    end
`else
    byp_s   = 1'b0;
    o_valid = ~empty_s & ~flush;
    o_data  = mem_rd_s;
`endif
    rd_en_s = o_valid & o_ready;
    i_ready = (~full_s | rd_en_s) & ~flush;
    wr_en_s = i_valid & i_ready;
    // A bypassed beat that is consumed never touches storage or pointers
    push_s  = wr_en_s & ~(byp_s & o_ready);
    pop_s   = rd_en_s & ~empty_s;
  end

  // Pointer advance; read and write pointers move independently
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    op_s = ifop_e'({push_s, pop_s});
    case (op_s)
      IFOP_IDLE: begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
      end
      IFOP_POP: begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end
      IFOP_PUSH: begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end
      IFOP_BOTH: begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end
      default: begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
      end
    endcase
  end

  // Pointer registers, cleared by reset or flush
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Occupancy from the wrap-extended pointer difference; no input path
  always_comb begin
    o_count = wr_ptr_r - rd_ptr_r;
    o_afull = (o_count >= AFULL_C);
  end

  npuarc_alb_dmp_ibp_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s & ~flush),
    .wr_idx  (wr_ptr_r[PTR_W-1:0]),
    .wr_data (i_data),
    .rd_idx  (rd_ptr_r[PTR_W-1:0]),
    .rd_data (mem_rd_s)
  );

endmodule

// File: tb/tb_npuarc_alb_dmp_ibp_fifo.sv
// Scoreboard bench for npuarc_alb_dmp_ibp_fifo (DEPTH=4): directed scenarios then random traffic.
module tb_npuarc_alb_dmp_ibp_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic             clk = 1'b0;
  logic             rst_a = 1'b1;
  logic             flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [WIDTH-1:0] i_data = '0;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_count;
  logic             o_afull;

  int n_checks = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] model_q[$];

  always #5 clk = ~clk;

  npuarc_alb_dmp_ibp_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk     (clk),
    .rst_a   (rst_a),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_afull (o_afull)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every settled cycle against the queue model, then advance the model
  always @(negedge clk) begin
    if (!rst_a) begin
      int  sz;
      bit  byp, exp_ov, exp_rd, exp_ir;
      sz  = model_q.size();
`ifdef NPUARC_IBP_FIFO_BYPASS_EN
      byp = (sz == 0) && i_valid && !flush;
`else
      byp = 1'b0;
`endif
      exp_ov = !flush && ((sz > 0) || byp);
      exp_rd = exp_ov && o_ready;
      exp_ir = !flush && ((sz < DEPTH) || exp_rd);
      check("o_valid", 32'(o_valid), 32'(exp_ov));
      check("i_ready", 32'(i_ready), 32'(exp_ir));
      check("o_count", 32'(o_count), 32'(sz));
      check("o_afull", 32'(o_afull), 32'(sz >= AFULL));
      if (o_valid && o_ready) begin
        if (byp) begin
          check("bypass_data", o_data, i_data);
        end else if (sz == 0) begin
          check("pop_from_empty", 32'd1, 32'd0);
        end else begin
          check("o_data", o_data, model_q[0]);
        end
      end
      if (flush) begin
        model_q.delete();
      end else begin
        if (exp_rd && !byp) void'(model_q.pop_front());
        if (i_valid && exp_ir && !(byp && o_ready)) model_q.push_back(i_data);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit f);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    o_ready = r;
    flush   = f;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_o_count", 32'(o_count), 32'd0);
    check("rst_o_afull", 32'(o_afull), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;

    // Fill with o_ready low, then hold a stalled 5th beat
    for (int k = 0; k < 4; k++) drive(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0);
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    // Stream at full occupancy: stalled beat enters first, then B0..
    drive(1'b1, 32'hA4, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b1, 32'hB0 + 32'(k), 1'b1, 1'b0);
    // Drain to two entries, then flush with a read and write attempted
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hEE, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Single beat into an empty FIFO with consumer ready
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream at count=3
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h90 + 32'(k), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_a = 1'b1;
    #1;
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_o_count", 32'(o_count), 32'd0);
    model_q.delete();
    @(posedge clk);
    #1 rst_a = 1'b0;
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'hC1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flush
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (DEPTH + 1) drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("final_empty", 32'(model_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
